// File: rtl/io_bus_arb.sv
// Two-master round-robin arbiter onto the debug unit's 8-bit-address / 32-bit-data IO port.
// One transaction at a time: IDLE -> ACCESS (1+WAIT_CYCLES cycles) -> RESP -> IDLE.
module io_bus_arb #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,

    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    output logic        io_rd,
    input  logic [31:0] io_din,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        last_gnt;
    logic        cap_id;
    logic        cap_we;

    logic        sel_valid;
    logic        sel_id;
    logic        sel_we;
    logic [7:0]  sel_addr;
    logic [31:0] sel_wdata;

    // On a tie the master that was not granted last wins.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sel_valid = m0_req | m1_req;
        sel_id    = 1'b0;
        if (m0_req && m1_req) begin
            sel_id = ~last_gnt;
        end else if (m1_req) begin
            sel_id = 1'b1;
        end
        sel_we    = sel_id ? m1_we    : m0_we;
        sel_addr  = sel_id ? m1_addr  : m0_addr;
        sel_wdata = sel_id ? m1_wdata : m0_wdata;
    end

    // io_addr/io_dout double as the captured address and write data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            last_gnt <= 1'b1;
            cap_id   <= 1'b0;
            cap_we   <= 1'b0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            m0_rdata <= 32'd0;
            m1_rdata <= 32'd0;
            io_addr  <= 8'd0;
            io_dout  <= 32'd0;
            io_we    <= 1'b0;
            io_rd    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            io_we   <= 1'b0;
            io_rd   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state    <= ACCESS;
                        busy     <= 1'b1;
                        cap_id   <= sel_id;
                        cap_we   <= sel_we;
                        last_gnt <= sel_id;
                        wait_cnt <= WAIT_LOAD;
                        io_addr  <= sel_addr;
                        io_dout  <= sel_wdata;
                        m0_gnt   <= ~sel_id;
                        m1_gnt   <= sel_id;
                        io_we    <= sel_we;
                        io_rd    <= ~sel_we;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state <= RESP;
                        if (!cap_we) begin
                            if (cap_id) m1_rdata <= io_din;
                            else        m0_rdata <= io_din;
                        end
                        m0_done <= ~cap_id;
                        m1_done <= cap_id;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arb.sv
// Directed bench for io_bus_arb: one instance with WAIT_CYCLES=0, one with WAIT_CYCLES=3.
// Inputs change and outputs are checked on the falling clock edge.
module tb_io_bus_arb;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Instance a: WAIT_CYCLES = 0
    logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_done;
    logic [7:0]  a_m0_addr;
    logic [31:0] a_m0_wdata, a_m0_rdata;
    logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_done;
    logic [7:0]  a_m1_addr;
    logic [31:0] a_m1_wdata, a_m1_rdata;
    logic [7:0]  a_io_addr;
    logic [31:0] a_io_dout, a_io_din;
    logic        a_io_we, a_io_rd, a_busy;

    // Instance b: WAIT_CYCLES = 3
    logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_done;
    logic [7:0]  b_m0_addr;
    logic [31:0] b_m0_wdata, b_m0_rdata;
    logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_done;
    logic [7:0]  b_m1_addr;
    logic [31:0] b_m1_wdata, b_m1_rdata;
    logic [7:0]  b_io_addr;
    logic [31:0] b_io_dout, b_io_din;
    logic        b_io_we, b_io_rd, b_busy;

    io_bus_arb #(.WAIT_CYCLES(0)) u_a (
        .clk(clk), .rstn(rstn),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
        .io_addr(a_io_addr), .io_dout(a_io_dout), .io_we(a_io_we), .io_rd(a_io_rd),
        .io_din(a_io_din), .busy(a_busy)
    );

    io_bus_arb #(.WAIT_CYCLES(3)) u_b (
        .clk(clk), .rstn(rstn),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
        .io_addr(b_io_addr), .io_dout(b_io_dout), .io_we(b_io_we), .io_rd(b_io_rd),
        .io_din(b_io_din), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        {a_m0_req, a_m0_we, a_m1_req, a_m1_we} = '0;
        {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
        a_m0_addr = '0; a_m0_wdata = '0; a_m1_addr = '0; a_m1_wdata = '0; a_io_din = '0;
        b_m0_addr = '0; b_m0_wdata = '0; b_m1_addr = '0; b_m1_wdata = '0; b_io_din = '0;
        step(); step();

        // Reset state
        check("rst_busy", a_busy, 0);
        check("rst_gnt", {a_m1_gnt, a_m0_gnt}, 0);
        check("rst_done", {a_m1_done, a_m0_done}, 0);
        check("rst_strobes", {a_io_we, a_io_rd}, 0);
        check("rst_io_addr", a_io_addr, 0);
        check("rst_io_dout", a_io_dout, 0);
        check("rst_m0_rdata", a_m0_rdata, 0);
        check("rst_m1_rdata", a_m1_rdata, 0);
        rstn = 1'b1;
        step();

        // 1: m0 read of 0x04, W=0
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 8'h04; a_io_din = 32'h0001_ABCD;
        step();
        check("t1_m0_gnt", a_m0_gnt, 1);
        check("t1_m1_gnt", a_m1_gnt, 0);
        check("t1_io_rd", a_io_rd, 1);
        check("t1_io_we", a_io_we, 0);
        check("t1_io_addr", a_io_addr, 8'h04);
        check("t1_busy", a_busy, 1);
        check("t1_done_early", a_m0_done, 0);
        a_m0_req = 1'b0;
        step();
        check("t1_m0_done", a_m0_done, 1);
        check("t1_m0_rdata", a_m0_rdata, 32'h0001_ABCD);
        check("t1_rd_once", a_io_rd, 0);
        check("t1_gnt_once", a_m0_gnt, 0);
        step();
        check("t1_busy_low", a_busy, 0);
        check("t1_done_once", a_m0_done, 0);

        // 2: m1 write of 0x1234_5678 to 0x0C
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 8'h0C; a_m1_wdata = 32'h1234_5678;
        a_io_din = 32'hDEAD_BEEF;
        step();
        check("t2_m1_gnt", a_m1_gnt, 1);
        check("t2_io_we", a_io_we, 1);
        check("t2_io_rd", a_io_rd, 0);
        check("t2_io_addr", a_io_addr, 8'h0C);
        check("t2_io_dout", a_io_dout, 32'h1234_5678);
        a_m1_req = 1'b0;
        step();
        check("t2_m1_done", a_m1_done, 1);
        check("t2_we_once", a_io_we, 0);
        check("t2_m1_rdata", a_m1_rdata, 0);
        check("t2_m0_rdata_kept", a_m0_rdata, 32'h0001_ABCD);
        step();
        check("t2_busy_low", a_busy, 0);

        // 3: both masters continuously right after reset -> 0,1,0,1 every 3 cycles
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 8'h10;
        a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 8'h14;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("t3_gnt_c%0d", i), {a_m1_gnt, a_m0_gnt},
                  {((i % 3 == 1) && ((i / 3) % 2 == 1)), ((i % 3 == 1) && ((i / 3) % 2 == 0))});
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        step(); step();
        check("t3_idle", a_busy, 0);

        // 5: m1 arrives during m0's ACCESS, waits for IDLE
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 8'h20; a_io_din = 32'h0000_5A5A;
        step();
        check("t5_m0_gnt", a_m0_gnt, 1);
        a_m0_req = 1'b0;
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 8'h24; a_m1_wdata = 32'hCAFE_0001;
        step();
        check("t5_m0_done", a_m0_done, 1);
        check("t5_m0_rdata", a_m0_rdata, 32'h0000_5A5A);
        check("t5_m1_wait_resp", a_m1_gnt, 0);
        step();
        check("t5_m1_wait_idle", a_m1_gnt, 0);
        check("t5_idle", a_busy, 0);
        step();
        check("t5_m1_gnt", a_m1_gnt, 1);
        check("t5_m1_addr", a_io_addr, 8'h24);
        a_m1_req = 1'b0;
        step();
        check("t5_m1_done", a_m1_done, 1);
        step();

        // 6: reset during a write's ACCESS
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 8'h30; a_m1_wdata = 32'h0BAD_F00D;
        step();
        check("t6_io_we", a_io_we, 1);
        a_m1_req = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("t6_async_we", a_io_we, 0);
        check("t6_async_gnt", a_m1_gnt, 0);
        check("t6_async_busy", a_busy, 0);
        step();
        check("t6_no_done", {a_m1_done, a_m0_done}, 0);
        rstn = 1'b1;
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 8'h08; a_io_din = 32'h7777_0007;
        a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 8'h0C;
        step();
        check("t6_gnt_m0_wins", {a_m1_gnt, a_m0_gnt}, 2'b01);
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        step();
        check("t6_m0_done", a_m0_done, 1);
        check("t6_m0_rdata", a_m0_rdata, 32'h7777_0007);
        step();

        // 4: WAIT_CYCLES=3, io_din changes during ACCESS
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 8'h18; b_io_din = 32'h1111_1111;
        step();
        check("t4_gnt", b_m0_gnt, 1);
        check("t4_rd_c1", b_io_rd, 1);
        check("t4_addr_c1", b_io_addr, 8'h18);
        b_m0_req = 1'b0; b_io_din = 32'h2222_2222;
        step();
        check("t4_rd_c2", b_io_rd, 0);
        check("t4_gnt_c2", b_m0_gnt, 0);
        check("t4_addr_c2", b_io_addr, 8'h18);
        check("t4_done_c2", b_m0_done, 0);
        b_io_din = 32'h3333_3333;
        step();
        check("t4_addr_c3", b_io_addr, 8'h18);
        check("t4_done_c3", b_m0_done, 0);
        b_io_din = 32'h4444_4444;
        step();
        check("t4_addr_c4", b_io_addr, 8'h18);
        check("t4_rd_c4", b_io_rd, 0);
        check("t4_done_c4", b_m0_done, 0);
        check("t4_busy_c4", b_busy, 1);
        step();
        check("t4_done_c5", b_m0_done, 1);
        check("t4_rdata", b_m0_rdata, 32'h4444_4444);
        b_io_din = 32'h5555_5555;
        step();
        check("t4_done_once", b_m0_done, 0);
        check("t4_busy_low", b_busy, 0);
        check("t4_rdata_held", b_m0_rdata, 32'h4444_4444);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/io_bus_arb.md
Name: io_bus_arb

Overview:
- Two-master arbiter for the 8-bit-address / 32-bit-data IO bus into the debug unit's IO port.
- Master 0 is the CPU load/store path. Master 1 is a debug/host master, e.g. a UART command engine.
- Serialises requests onto the single slave port using round-robin priority, drives one bus transaction at a time, and returns read data with a done pulse.
- Sits between the CPU memory stage, the host master, and the debug unit's io_addr/io_dout/io_we/io_rd/io_din.

Parameters:
WAIT_CYCLES, 0, extra cycles the address is held before io_din is sampled (0..15)

Ports:
clk  in  1  arbiter clock, same domain as the slave's IO bus clock
rstn  in  1  reset, asynchronous, active-low
m0_req  in  1  master 0 request; hold until m0_gnt
m0_we  in  1  master 0: 1 = write, 0 = read
m0_addr  in  8  master 0 IO address
m0_wdata  in  32  master 0 write data
m0_gnt  out  1  one-cycle pulse: master 0 command captured
m0_done  out  1  one-cycle pulse: master 0 transaction complete
m0_rdata  out  32  master 0 read data, valid when m0_done=1
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata  same as master 0, for master 1
io_addr  out  8  slave address
io_dout  out  32  slave write data
io_we  out  1  slave write strobe
io_rd  out  1  slave read strobe
io_din  in  32  slave read data, combinational from io_addr
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE; last-granted pointer = 1, so master 0 wins the first tie.
  - All outputs 0: gnt, done, rdata, io_addr, io_dout, io_we, io_rd, busy.
  - Captured command registers cleared.
- Reset mid-transaction aborts immediately. No done is issued, and io_we/io_rd drop asynchronously.
- State machine (IDLE, ACCESS, RESP):
  - IDLE, no req: stay.
  - IDLE, exactly one req: select that master.
  - IDLE, both req: select the master not equal to the last-granted pointer.
  - On select, at the clock edge: capture we/addr/wdata and master id, update the pointer, load wait counter = WAIT_CYCLES, go to ACCESS.
  - ACCESS: stay while wait counter != 0, decrementing it each cycle. When the counter == 0: sample io_din into the selected master's rdata register (reads only), go to RESP.
  - RESP: go to IDLE.
- Strobes and outputs (all registered; no combinational path from req to any output):
  - gnt of the selected master is high exactly in the first ACCESS cycle.
  - io_addr and io_dout are driven from the captured command for the whole ACCESS phase and hold their last value otherwise.
  - io_we (write) or io_rd (read) is high only in the first ACCESS cycle. This gives exactly one strobe per transaction, because slave reads have side effects such as clearing a valid flag.
  - done of the selected master is high exactly in the RESP cycle.
  - rdata holds its value until that master's next read completes; it is unchanged by writes.
- Latency with WAIT_CYCLES=W, req sampled at edge k:
  - ACCESS spans cycles k+1 .. k+1+W; gnt and strobe occur at k+1.
  - done at k+2+W; IDLE at k+3+W.
  - Minimum transaction period is 3+W cycles.
- Request rules:
  - A master must hold req, we, addr and wdata stable until gnt. The arbiter samples them only in IDLE.
  - Deasserting req before selection withdraws it, with no side effects.
  - req still high after gnt is treated as a new request once the arbiter returns to IDLE.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1. A single requester is granted every 3+W cycles without waiting on the other.
- The pointer updates only on a grant; idle cycles do not change priority.
- Requests arriving while busy=1 wait; none is dropped or reordered.

Test Plan:
1. Reset, then m0 read addr 0x04 (W=0), io_din=0x0001_ABCD -> m0_gnt and io_rd high one cycle at k+1, io_addr=0x04; m0_done at k+2 with m0_rdata=0x0001ABCD; busy low at k+3.
2. m1 write addr 0x0C, wdata 0x1234_5678 -> io_we one cycle, io_dout=0x12345678, io_addr=0x0C; m1_done two cycles after the request edge; m1_rdata unchanged.
3. m0 and m1 requesting the same cycle, continuously, for 4 transactions right after reset -> grant order m0,m1,m0,m1, one grant every 3 cycles; no cycle where both gnt are high.
4. WAIT_CYCLES=3, m0 read 0x18 with io_din changing during ACCESS -> io_rd high only in the first ACCESS cycle, io_addr held 4 cycles; rdata equals io_din in the 4th ACCESS cycle; done 5 cycles after the request edge.
5. m1 requesting while m0's transaction is in ACCESS -> m1 granted the cycle after m0 returns to IDLE; m0's done is unaffected.
6. rstn low during ACCESS of a write -> io_we, gnt and busy go to 0 at once; no done; after release, a fresh m0 request completes normally with m0 winning.
